// File: rtl/motoro3_pkg.sv
// Shared constants, FSM encoding and step-wrap helper for the 3-phase
// step/PWM sequencer.
package motoro3_pkg;

    localparam int STEP_NUM = 12;
    localparam int SPD_W    = 25;
    localparam int PWM_W    = 12;
    localparam int PL_W     = 16;
    localparam int STEP_W   = 4;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_NUM - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } m3_state_e;

    // Out-of-range indices fold back onto a legal step instead of running away.
    function automatic logic [STEP_W-1:0] step_next(
        input logic [STEP_W-1:0] cur,
        input logic              dir
    );
        logic [STEP_W-1:0] nxt;
        if (dir) begin
            if (cur >= STEP_LAST) begin
                nxt = STEP_ZERO;
            end else begin
                nxt = cur + STEP_ONE;
            end
        end else begin
            if ((cur == STEP_ZERO) || (cur > STEP_LAST)) begin
                nxt = STEP_LAST;
            end else begin
                nxt = cur - STEP_ONE;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/motoro3_pwm_period_gen.sv
// PWM period counter with a period-aligned on-length latch, so a new
// on-length only takes effect at the start of the next period.
module motoro3_pwm_period_gen
    import motoro3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [PWM_W-1:0] pwm_len,
    input  logic [PL_W-1:0]  pl_len,
    output logic             pwm_out,
    output logic             period_start
);

    localparam logic [PWM_W-1:0] CNT_ZERO = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0] CNT_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};

    logic [PWM_W-1:0] pwm_cnt_r;
    logic [PL_W-1:0]  pl_latch_r;
    logic             pwm_out_r;
    logic             period_start_r;

    logic [PWM_W-1:0] pwm_cnt_s;
    logic [PL_W-1:0]  pl_latch_s;
    logic             pwm_out_s;
    logic             period_start_s;
    logic             len_nz_s;
    logic             wrap_s;
    logic [PL_W-1:0]  cnt_ext_s;

    assign len_nz_s  = (pwm_len != CNT_ZERO);
    // The +1 is done one bit wider so a shrunk period wraps instead of overflowing.
    assign wrap_s    = ({1'b0, pwm_cnt_r} + {1'b0, CNT_ONE}) >= {1'b0, pwm_len};
    assign cnt_ext_s = {{(PL_W-PWM_W){1'b0}}, pwm_cnt_r};

    // Next values for counter, latch, gate and period-start pulse.
    always_comb begin
        pwm_cnt_s      = pwm_cnt_r;
        pl_latch_s     = pl_latch_r;
        pwm_out_s      = 1'b0;
        period_start_s = 1'b0;
        if (start) begin
            pwm_cnt_s      = CNT_ZERO;
            pl_latch_s     = pl_len;
            period_start_s = len_nz_s;
        end else if (run && len_nz_s) begin
            pwm_out_s = (cnt_ext_s < pl_latch_r);
            if (wrap_s) begin
                pwm_cnt_s      = CNT_ZERO;
                pl_latch_s     = pl_len;
                period_start_s = 1'b1;
            end else begin
                pwm_cnt_s      = pwm_cnt_r + CNT_ONE;
                period_start_s = 1'b0;
            end
        end else begin
            pwm_cnt_s = CNT_ZERO;
        end
    end

    // Period state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_r      <= CNT_ZERO;
            pl_latch_r     <= {PL_W{1'b0}};
            pwm_out_r      <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            pwm_cnt_r      <= pwm_cnt_s;
            pl_latch_r     <= pl_latch_s;
            pwm_out_r      <= pwm_out_s;
            period_start_r <= period_start_s;
        end
    end

    assign pwm_out      = pwm_out_r;
    assign period_start = period_start_r;

endmodule

// File: rtl/motoro3_step_pwm_sequencer.sv
// Commutation step sequencer: run/idle FSM, step-length counter and step
// index, wrapped around the PWM period generator.
module motoro3_step_pwm_sequencer
    import motoro3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              m3r_enable,
    input  logic              m3r_dir,
    input  logic [SPD_W-1:0]  m3r_stepCNT_speedSET,
    input  logic [PWM_W-1:0]  m3r_pwmLenWant,
    input  logic [PL_W-1:0]   plLen,
    output logic [STEP_W-1:0] lcStep,
    output logic              stepTick,
    output logic              pwmOut,
    output logic              pwmPeriodStart
);

    localparam logic [SPD_W-1:0] SCNT_ZERO = {SPD_W{1'b0}};
    localparam logic [SPD_W-1:0] SCNT_ONE  = {{(SPD_W-1){1'b0}}, 1'b1};

    m3_state_e         state_r;
    m3_state_e         state_s;
    logic              start_s;
    logic              run_s;

    logic [SPD_W-1:0]  step_cnt_r;
    logic [STEP_W-1:0] lc_step_r;
    logic              step_tick_r;
    logic [SPD_W-1:0]  step_cnt_s;
    logic [STEP_W-1:0] lc_step_s;
    logic              step_tick_s;
    logic [SPD_W:0]    step_lim_s;
    logic              stall_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = m3r_enable ? RUN : IDLE;
            RUN:     state_s = m3r_enable ? RUN : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM decode: start marks the IDLE->RUN edge, run is a RUN cycle that stays in RUN.
    always_comb begin
        start_s = 1'b0;
        run_s   = 1'b0;
        case (state_r)
            IDLE:    start_s = m3r_enable;
            RUN:     run_s   = m3r_enable;
            default: begin
                start_s = 1'b0;
                run_s   = 1'b0;
            end
        endcase
    end

    assign step_lim_s = {1'b0, m3r_stepCNT_speedSET} - {1'b0, SCNT_ONE};
    assign stall_s    = (m3r_stepCNT_speedSET <= SCNT_ONE);

    // Step counter and index advance; >= lets a shortened step end at once.
    always_comb begin
        step_cnt_s  = SCNT_ZERO;
        lc_step_s   = lc_step_r;
        step_tick_s = 1'b0;
        if (run_s && !stall_s) begin
            if ({1'b0, step_cnt_r} >= step_lim_s) begin
                step_cnt_s  = SCNT_ZERO;
                lc_step_s   = step_next(lc_step_r, m3r_dir);
                step_tick_s = 1'b1;
            end else begin
                step_cnt_s  = step_cnt_r + SCNT_ONE;
            end
        end else begin
            step_cnt_s = SCNT_ZERO;
        end
    end

    // Step state and registered step outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_r  <= SCNT_ZERO;
            lc_step_r   <= STEP_ZERO;
            step_tick_r <= 1'b0;
        end else begin
            step_cnt_r  <= step_cnt_s;
            lc_step_r   <= lc_step_s;
            step_tick_r <= step_tick_s;
        end
    end

    motoro3_pwm_period_gen u_pwm (
        .clk          (clk),
        .rst          (rst),
        .start        (start_s),
        .run          (run_s),
        .pwm_len      (m3r_pwmLenWant),
        .pl_len       (plLen),
        .pwm_out      (pwmOut),
        .period_start (pwmPeriodStart)
    );

    assign lcStep   = lc_step_r;
    assign stepTick = step_tick_r;

endmodule

// File: tb/tb_motoro3_step_pwm_sequencer.sv
// Bench for motoro3_step_pwm_sequencer: directed scenarios plus random
// stimulus, all checked every cycle against a behavioural model.
module tb_motoro3_step_pwm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dir;
    logic [24:0] spd;
    logic [11:0] len;
    logic [15:0] pl;
    logic [3:0]  lcStep;
    logic        stepTick;
    logic        pwmOut;
    logic        pwmPeriodStart;

    int total = 0;
    int bad   = 0;

    bit m_valid = 1'b0;
    bit m_run   = 1'b0;
    int m_lc    = 0;
    int m_scnt  = 0;
    int m_pcnt  = 0;
    int m_latch = 0;
    bit m_tick  = 1'b0;
    bit m_out   = 1'b0;
    bit m_pps   = 1'b0;

    always #5 clk = ~clk;

    motoro3_step_pwm_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .m3r_enable           (en),
        .m3r_dir              (dir),
        .m3r_stepCNT_speedSET (spd),
        .m3r_pwmLenWant       (len),
        .plLen                (pl),
        .lcStep               (lcStep),
        .stepTick             (stepTick),
        .pwmOut               (pwmOut),
        .pwmPeriodStart       (pwmPeriodStart)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the outputs each clock edge must produce.
    always @(posedge clk) begin : model
        int  len_i;
        int  spd_i;
        bit  entering;
        bit  staying;
        len_i = int'(len);
        spd_i = int'(spd);
        if (rst === 1'b1) begin
            m_valid = 1'b1;
            m_run = 1'b0; m_lc = 0; m_scnt = 0; m_pcnt = 0; m_latch = 0;
            m_tick = 1'b0; m_out = 1'b0; m_pps = 1'b0;
        end else if (m_valid) begin
            entering = !m_run && (en === 1'b1);
            staying  = m_run && (en === 1'b1);
            if (entering) begin
                m_pcnt = 0; m_latch = int'(pl); m_pps = (len_i != 0); m_out = 1'b0;
            end else if (staying && len_i != 0) begin
                m_out = (m_pcnt < m_latch);
                if (m_pcnt + 1 >= len_i) begin
                    m_pcnt = 0; m_latch = int'(pl); m_pps = 1'b1;
                end else begin
                    m_pcnt = m_pcnt + 1; m_pps = 1'b0;
                end
            end else begin
                m_pcnt = 0; m_pps = 1'b0; m_out = 1'b0;
            end
            if (staying && spd_i >= 2) begin
                if (m_scnt + 1 >= spd_i) begin
                    m_scnt = 0; m_tick = 1'b1;
                    m_lc = dir ? (m_lc + 1) % 12 : (m_lc + 11) % 12;
                end else begin
                    m_scnt = m_scnt + 1; m_tick = 1'b0;
                end
            end else begin
                m_scnt = 0; m_tick = 1'b0;
            end
            m_run = (en === 1'b1);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("lcStep", 32'(lcStep), m_lc);
            chk("stepTick", 32'(stepTick), 32'(m_tick));
            chk("pwmOut", 32'(pwmOut), 32'(m_out));
            chk("pwmPeriodStart", 32'(pwmPeriodStart), 32'(m_pps));
        end
    end

    task automatic wait_pps(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pwmPeriodStart !== 1'b1 && n < bound);
        chk(name, 32'(pwmPeriodStart), 32'd1);
    endtask

    task automatic wait_tick(input string name, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stepTick !== 1'b1 && n < bound);
        chk(name, 32'(stepTick), 32'd1);
    endtask

    task automatic wait_lc(input string name, input int val, input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(lcStep) != val && n < bound);
        chk(name, 32'(lcStep), val);
    endtask

    initial begin
        int ticks;
        int highs;
        int starts;
        int lc0;
        int rev_exp[3];
        rev_exp = '{11, 10, 9};
        rst = 1'b1; en = 1'b0; dir = 1'b1;
        spd = 25'd10; len = 12'd8; pl = 16'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_lcStep", 32'(lcStep), 32'd0);
        chk("reset_pwmOut", 32'(pwmOut), 32'd0);
        chk("reset_stepTick", 32'(stepTick), 32'd0);
        chk("reset_pps", 32'(pwmPeriodStart), 32'd0);

        // Forward run: 121 cycles span 12 steps and 16 period starts.
        en = 1'b1;
        ticks = 0; highs = 0; starts = 0;
        for (int i = 1; i <= 121; i++) begin
            @(negedge clk);
            if (i == 1) chk("first_run_pps", 32'(pwmPeriodStart), 32'd1);
            if (stepTick === 1'b1) ticks++;
            if (pwmOut === 1'b1) highs++;
            if (pwmPeriodStart === 1'b1) starts++;
        end
        chk("fwd_tick_count", ticks, 32'd12);
        chk("fwd_lc_wrapped", 32'(lcStep), 32'd0);
        chk("fwd_pps_count", starts, 32'd16);
        chk("fwd_on_count", highs, 32'd45);

        // Reverse from step 0.
        dir = 1'b0; spd = 25'd4;
        for (int k = 0; k < 3; k++) begin
            wait_tick("rev_tick", 10);
            chk("rev_lc", 32'(lcStep), rev_exp[k]);
        end

        // On-length change mid-period only applies at the next period.
        pl = 16'd2;
        wait_pps("pl2_pps", 20);
        highs = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (pwmOut === 1'b1) highs++;
            if (i == 4) pl = 16'd6;
        end
        chk("old_period_on", highs, 32'd2);
        chk("new_period_pps", 32'(pwmPeriodStart), 32'd1);
        highs = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (pwmOut === 1'b1) highs++;
        end
        chk("new_period_on", highs, 32'd6);
        pl = 16'd20;
        @(negedge clk);
        wait_pps("pl20_pps", 20);
        highs = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (pwmOut === 1'b1) highs++;
        end
        chk("full_on", highs, 32'd16);

        // Step length shortened mid-step, then stall guard.
        spd = 25'd100;
        wait_tick("spd100_tick", 110);
        repeat (50) @(negedge clk);
        spd = 25'd5;
        @(negedge clk);
        chk("shorten_tick", 32'(stepTick), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("spd5_tick", 32'(stepTick), (i % 5 == 0) ? 32'd1 : 32'd0);
        end
        spd = 25'd1;
        lc0 = int'(lcStep);
        ticks = 0;
        repeat (30) begin
            @(negedge clk);
            if (stepTick === 1'b1) ticks++;
        end
        chk("stall_ticks", ticks, 32'd0);
        chk("stall_lc", 32'(lcStep), lc0);

        // Enable drop at step 7 while the gate is high, then re-enable.
        spd = 25'd3; dir = 1'b1;
        wait_lc("reach_lc7", 7, 60);
        chk("pre_drop_out", 32'(pwmOut), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("drop_out", 32'(pwmOut), 32'd0);
        chk("drop_lc", 32'(lcStep), 32'd7);
        chk("drop_tick", 32'(stepTick), 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_lc", 32'(lcStep), 32'd7);
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) chk("rerun_pps", 32'(pwmPeriodStart), 32'd1);
            chk("rerun_tick", 32'(stepTick), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("rerun_lc", 32'(lcStep), 32'd8);

        // Random stimulus, checked by the per-cycle model comparison.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) spd = 25'($urandom_range(0, 9));
            if ($urandom_range(0, 49) == 0) len = 12'($urandom_range(0, 10));
            if ($urandom_range(0, 9) == 0) pl = 16'($urandom_range(0, 12));
        end

        // Reset mid-step and mid-period with the gate high.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; dir = 1'b1; spd = 25'd50; len = 12'd8; pl = 16'd20;
        repeat (20) @(negedge clk);
        chk("pre_rst_out", 32'(pwmOut), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_lc", 32'(lcStep), 32'd0);
        chk("rst_tick", 32'(stepTick), 32'd0);
        chk("rst_out", 32'(pwmOut), 32'd0);
        chk("rst_pps", 32'(pwmPeriodStart), 32'd0);
        rst = 1'b0; len = 12'd0;
        highs = 0; starts = 0;
        repeat (30) begin
            @(negedge clk);
            if (pwmOut === 1'b1) highs++;
            if (pwmPeriodStart === 1'b1) starts++;
        end
        chk("len0_on", highs, 32'd0);
        chk("len0_pps", starts, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
